cin_stream_arbiter: RTL and testbench

// Round-robin, packet-granular arbiter that shares one CIN stream (data + valid, no backpressure)

---
 rtl/cin_stream_arbiter.sv | 119 +++++++++++
 tb/tb_cin_stream_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cin_stream_arbiter.sv
// Round-robin packet arbiter merging P_NUM_SRC sources onto one CIN stream; src_valid->src_ready +1, ->valid/data +2.
// Owner keeps the bus until its last beat, then P_GAP_CYCLES idle cycles; the output stream has no backpressure.
module cin_stream_arbiter #(
  parameter int P_CIN_DATA_WIDTH = 16,
  parameter int P_NUM_SRC        = 4,
  parameter int P_GAP_CYCLES     = 2,
  localparam int GW              = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [P_NUM_SRC*P_CIN_DATA_WIDTH-1:0] src_data,
  input  logic [P_NUM_SRC-1:0]                  src_valid,
  input  logic [P_NUM_SRC-1:0]                  src_last,
  output logic [P_NUM_SRC-1:0]                  src_ready,
  output logic [P_CIN_DATA_WIDTH-1:0]           data,
  output logic                                  valid,
  output logic                                  busy,
  output logic [GW-1:0]                         grant_id
);

  localparam int CW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'((P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_e;

  state_e                        state_q, state_d;
  logic [GW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]                 grant_q, grant_d;
  logic [P_NUM_SRC-1:0]          ready_q, ready_d;
  logic [P_CIN_DATA_WIDTH-1:0]   data_q, data_d;
  logic                          valid_q, valid_d;
  logic [CW-1:0]                 gap_q, gap_d;

  logic                          any_req;
  logic [GW-1:0]                 pick;
  int                            idx;
  logic                          beat_acc;

  // First requester at or after rr_ptr, wrapping past the top index.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      idx = (int'(rr_ptr_q) + i) % P_NUM_SRC;
      if (!any_req && src_valid[idx]) begin
        any_req = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

  assign beat_acc = src_valid[grant_q] & ready_q[grant_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    ready_d  = ready_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d       = pick;
          ready_d       = '0;
          ready_d[pick] = 1'b1;
          state_d       = S_XFER;
        end
      end
      S_XFER: begin
        // A bubble (src_valid low) simply leaves valid_d at 0 and holds the grant.
        if (beat_acc) begin
          valid_d = 1'b1;
          data_d  = src_data[int'(grant_q)*P_CIN_DATA_WIDTH +: P_CIN_DATA_WIDTH];
          if (src_last[grant_q]) begin
            rr_ptr_d = (int'(grant_q) == P_NUM_SRC - 1) ? '0 : grant_q + 1'b1;
            ready_d  = '0;
            gap_d    = GAP_LOAD;
            state_d  = (P_GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
    end
  end

  assign src_ready = ready_q;
  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_cin_stream_arbiter.sv
// Bench for cin_stream_arbiter: random packet sources against a packet-timeline reference model.
module tb_cin_stream_arbiter;

  localparam int W = 16;
  localparam int N = 4;
  localparam int G = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_valid, src_last, src_ready;
  logic [W-1:0]     data;
  logic             valid, busy;
  logic [1:0]       grant_id;

  cin_stream_arbiter #(.P_CIN_DATA_WIDTH(W), .P_NUM_SRC(N), .P_GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .data(data), .valid(valid),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner = source holding the bus (-1 none), free_at = first cycle arbitration may happen.
  int           owner = -1;
  int           free_at = 0;
  int           ptr = 0;
  int           cyc = 0;
  int           e_grant = 0;
  logic [W-1:0] e_data = '0;
  logic         e_valid = 1'b0;
  logic         e_busy = 1'b0;
  logic [N-1:0] e_ready = '0;

  // Source generators.
  int           rem [N];
  int           seq [N];
  logic [N-1:0] acc;
  int           start_pct, bubble_pct, len_min, len_max;
  bit           all_req;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (all_req) begin
        src_valid[i]       = 1'b1;
        src_last[i]        = 1'b0;
        src_data[i*W +: W] = 16'hA000 | 16'(i);
      end else begin
        if (rem[i] == 0 && $urandom_range(99) < start_pct)
          rem[i] = len_min + int'($urandom_range(len_max - len_min));
        src_valid[i]       = (rem[i] > 0) && ($urandom_range(99) >= bubble_pct);
        src_last[i]        = (rem[i] == 1);
        src_data[i*W +: W] = {4'(i), 12'(seq[i])};
      end
    end
  endtask

  task automatic model();
    bit found;
    if (!rst_n) begin
      owner = -1; ptr = 0; free_at = cyc + 1;
      e_valid = 1'b0; e_data = '0; e_ready = '0; e_busy = 1'b0; e_grant = 0;
      return;
    end
    e_valid = 1'b0;
    if (owner >= 0) begin
      if (src_valid[owner]) begin
        e_valid = 1'b1;
        e_data  = src_data[owner*W +: W];
        if (src_last[owner]) begin
          ptr     = (owner + 1) % N;
          free_at = cyc + 1 + G;
          owner   = -1;
        end
      end
    end else if (cyc >= free_at && src_valid != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && src_valid[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          found = 1'b1;
        end
      end
      e_grant = owner;
    end
    e_ready = '0;
    if (owner >= 0) e_ready[owner] = 1'b1;
    e_busy = (owner >= 0) || (cyc + 1 < free_at);
  endtask

  task automatic step();
    @(negedge clk);
    chk("valid", 32'(valid), 32'(e_valid));
    chk("data", 32'(data), 32'(e_data));
    chk("src_ready", 32'(src_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_id", 32'(grant_id), 32'(e_grant));
    acc = src_valid & src_ready & {N{rst_n}};
    model();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && rem[i] > 0) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 1;
    end
    src_data = '0; src_valid = '0; src_last = '0;
    start_pct = 0; bubble_pct = 0; len_min = 1; len_max = 1;
    rst_n = 1'b0;
    all_req = 1'b1;
    drive();
    @(posedge clk);
    #1;
    repeat (3) step();

    // Saturated load with 2-beat packets: strict rotation and fixed gaps.
    rst_n = 1'b1;
    all_req = 1'b0;
    start_pct = 100; bubble_pct = 0; len_min = 2; len_max = 2;
    drive();
    repeat (300) step();

    // Mixed traffic with bubbles, single-beat packets and occasional resets mid-stream.
    start_pct = 40; bubble_pct = 20; len_min = 1; len_max = 8;
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(249) != 0);
      step();
    end

    // Sparse traffic: long IDLE stretches and lone requesters at arbitrary rr_ptr.
    rst_n = 1'b1;
    start_pct = 3; bubble_pct = 30; len_min = 1; len_max = 6;
    repeat (1000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
